// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry and scanout FSM states shared by the scanout reader
package fb_pkg;
   localparam int FB_W = 240;
   localparam int FB_H = 160;
   localparam int FB_ADDR_W = 19;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} scan_state_t;
endpackage

// File: rtl/line_buffer_2bank.sv
// line_buffer_2bank: ping-pong line store, two 240x24 banks, one write port and a synchronous read port
module line_buffer_2bank
   import fb_pkg::*;
(
   input  logic        Clk,
   input  logic        i_we,
   input  logic        i_wbank,
   input  logic [7:0]  i_wcol,
   input  logic [23:0] i_wdata,
   input  logic        i_rbank,
   input  logic [7:0]  i_rcol,
   output logic [23:0] o_rdata
);
   logic [23:0] r_mem [2][FB_W];
   always_ff @(posedge Clk) begin
      if (i_we) r_mem[i_wbank][i_wcol] <= i_wdata;
      o_rdata <= r_mem[i_rbank][i_rcol];
   end
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: prefetches one framebuffer row per two scanlines into a ping-pong buffer
// and streams it 2x2-upscaled into a 480x320 window of the VGA raster.
module fb_scanout_reader
   import fb_pkg::*;
#(
   parameter int FB_RD_LAT = 1,
   parameter int WIN_X0    = 80,
   parameter int WIN_Y0    = 80
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 ScanEn,
   input  logic [9:0]           DRAWX,
   input  logic [9:0]           DRAWY,
   output logic [FB_ADDR_W-1:0] fb_read_address,
   output logic                 fb_rd_en,
   input  logic [23:0]          fb_data,
   output logic [7:0]           R,
   output logic [7:0]           G,
   output logic [7:0]           B,
   output logic                 fetch_busy,
   output logic                 underrun
);
   localparam logic [9:0] X0 = 10'(WIN_X0), X1 = 10'(WIN_X0 + 2 * FB_W);
   localparam logic [9:0] Y0 = 10'(WIN_Y0), Y1 = 10'(WIN_Y0 + 2 * FB_H);
   scan_state_t r_state, w_next;
   logic [7:0] r_row, r_col, r_acol, w_trow, w_s, w_c;
   logic [1:0] r_dcnt, r_valid;
   logic [FB_RD_LAT-1:0] r_den;
   logic [7:0] r_dcol [FB_RD_LAT];
   logic r_show, w_inrows, w_inwin, w_trig, w_done, w_we;
   logic [23:0] w_rdata;

   assign w_s = 8'((DRAWY - Y0) >> 1);
   assign w_c = 8'((DRAWX - X0) >> 1);
   assign w_inrows = DRAWY >= Y0 && DRAWY < Y1;
   assign w_inwin = w_inrows && DRAWX >= X0 && DRAWX < X1;
   assign w_trow = DRAWY == Y0 - 10'd1 ? 8'd0 : w_s + 8'd1;
   // even window lines prefetch the next source row; the last source row has no successor
   assign w_trig = ScanEn && DRAWX == 10'd0 &&
                   (DRAWY == Y0 - 10'd1 || (w_inrows && DRAWY[0] == Y0[0] && w_s != 8'(FB_H - 1)));
   assign w_done = r_state == DRAIN && r_dcnt == 2'(FB_RD_LAT);
   // a trigger flushes the delay line, so any return still in flight is dropped
   assign w_we = r_den[FB_RD_LAT-1] && !w_trig && !Reset;
   assign fetch_busy = r_state != IDLE;
   assign {R, G, B} = r_show ? w_rdata : 24'd0;

   always_comb begin
      w_next = r_state;
      if (w_trig) w_next = FETCH;
      else if (r_state == FETCH && r_col == 8'(FB_W - 1)) w_next = DRAIN;
      else if (w_done) w_next = IDLE;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= IDLE;
         r_row <= 8'd0;
         r_col <= 8'd0;
         r_dcnt <= 2'd0;
         r_valid <= 2'b00;
         r_den <= '0;
         r_show <= 1'b0;
         fb_read_address <= '0;
         fb_rd_en <= 1'b0;
         underrun <= 1'b0;
      end else begin
         r_state <= w_next;
         fb_rd_en <= !w_trig && r_state == FETCH;
         if (!w_trig && r_state == FETCH) fb_read_address <= 19'(r_row) * 19'(FB_W) + 19'(r_col);
         r_den[0] <= fb_rd_en && !w_trig;
         for (int i = 1; i < FB_RD_LAT; i++) r_den[i] <= r_den[i-1] && !w_trig;
         if (w_trig) begin
            r_row <= w_trow;
            r_col <= 8'd0;
            r_dcnt <= 2'd0;
            r_valid[w_trow[0]] <= 1'b0;
         end else begin
            r_col <= r_state == FETCH ? r_col + 8'd1 : r_col;
            r_dcnt <= r_state == DRAIN ? r_dcnt + 2'd1 : 2'd0;
            if (w_done) r_valid[r_row[0]] <= 1'b1;
         end
         r_show <= ScanEn && w_inwin && r_valid[w_s[0]];
         underrun <= underrun || (ScanEn && w_inwin && !r_valid[w_s[0]]);
      end
   end

   always_ff @(posedge Clk) begin
      r_acol <= r_col;
      r_dcol[0] <= r_acol;
      for (int i = 1; i < FB_RD_LAT; i++) r_dcol[i] <= r_dcol[i-1];
   end

   line_buffer_2bank u_lb (
      .Clk     (Clk),
      .i_we    (w_we),
      .i_wbank (r_row[0]),
      .i_wcol  (r_dcol[FB_RD_LAT-1]),
      .i_wdata (fb_data),
      .i_rbank (w_s[0]),
      .i_rcol  (w_inwin ? w_c : 8'd0),
      .o_rdata (w_rdata)
   );
endmodule
